// File: rtl/cpu_memory_stage_p.sv
// Stack CPU stage 3a->4a: branch resolve, push/pop selection, and a req/ack bus FSM
// for LOAD/STORE that stalls upstream while a transaction is outstanding.
module cpu_memory_stage_p #(
   parameter int XLEN    = 32,
   parameter int TAGW    = 3,
   parameter int POPW    = 11,
   parameter int IMMW    = 16,
   parameter int BUS_AW  = 8,
   parameter int POP_ALU = 3,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic                 in_valid_3a,
   output logic                 in_ready_3a,
   input  logic                 alu__cond_3a,
   input  logic [XLEN-1:0]      alu__out_3a,
   input  logic [1:0]           c__branch_3a,
   input  logic [2:0]           c__to_push_3a,
   input  logic [1:0]           c__mem_3a,
   input  logic [47:0]          instruction_3a,
   input  logic [XLEN-1:0]      pc_3a,
   input  logic [TAGW+XLEN-1:0] r0_3a,
   input  logic [TAGW+XLEN-1:0] r1_3a,
   input  logic [POPW-1:0]      st__to_pop_3a,
   output logic                 valid_4a,
   output logic                 kill_4a,
   output logic [XLEN-1:0]      branch_target_4a,
   output logic [XLEN-1:0]      pc_4a,
   output logic [2:0]           c__to_push_4a,
   output logic [TAGW+XLEN-1:0] st__to_push_4a,
   output logic [POPW-1:0]      st__to_pop_4a,
   output logic                 fault_4a,
   output logic                 bus__req,
   output logic                 bus__we,
   output logic [BUS_AW-1:0]    bus__addr,
   output logic [XLEN-1:0]      bus__wdata,
   input  logic                 bus__ack,
   input  logic [XLEN-1:0]      bus__rdata
);
   localparam int SW = TAGW + XLEN;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [TAGW-1:0] TYPE_INTEGER = TAGW'(1);
   localparam logic [1:0] UC_BR_NONE = 2'd0, UC_BR_REL = 2'd1, UC_BR_REL_COND = 2'd2, UC_BR_ALU = 2'd3;
   localparam logic [2:0] UC_PUSHALU = 3'd1, UC_PUSHIMM = 3'd2, UC_PUSHREG0 = 3'd3,
                          UC_PUSHREG1 = 3'd4, UC_PUSHBUS = 3'd5;
   localparam logic [1:0] UC_MEM_LOAD = 2'd1, UC_MEM_STORE = 2'd2;

   typedef struct packed {
      logic            cond;
      logic [XLEN-1:0] alu;
      logic [1:0]      br;
      logic [2:0]      push;
      logic [1:0]      mem;
      logic [47:0]     instr;
      logic [XLEN-1:0] pc;
      logic [SW-1:0]   r0;
      logic [SW-1:0]   r1;
      logic [POPW-1:0] pop;
   } op_t;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          state;
   op_t             live, held, cur;
   logic [CW-1:0]   cnt;
   logic            is_mem, accept_mem, tmo, retire;
   logic            kill_c;
   logic [XLEN-1:0] target_c;
   logic [SW-1:0]   push_c;
   logic [POPW-1:0] pop_c;
   logic            unused_bits;

   assign live = '{alu__cond_3a, alu__out_3a, c__branch_3a, c__to_push_3a, c__mem_3a,
                   instruction_3a, pc_3a, r0_3a, r1_3a, st__to_pop_3a};
   // While a transaction is outstanding the retiring fields come from the capture.
   assign cur         = (state == S_IDLE) ? live : held;
   assign in_ready_3a = (state == S_IDLE);
   assign is_mem      = (live.mem == UC_MEM_LOAD) || (live.mem == UC_MEM_STORE);
   assign accept_mem  = (state == S_IDLE) && in_valid_3a && is_mem;
   assign tmo         = (state == S_WAIT) && !bus__ack && (cnt == CW'(TIMEOUT - 1));
   assign retire      = ((state == S_IDLE) && in_valid_3a && !is_mem) ||
                        ((state == S_WAIT) && (bus__ack || tmo));
   assign unused_bits = ^{cur.instr[47:SW], cur.mem};

   always_comb begin
      kill_c   = 1'b0;
      target_c = '0;
      case (cur.br)
         UC_BR_REL: begin
            kill_c   = 1'b1;
            target_c = cur.pc + {{(XLEN-IMMW){cur.instr[IMMW-1]}}, cur.instr[IMMW-1:0]};
         end
         UC_BR_REL_COND: begin
            kill_c   = cur.cond;
            target_c = cur.pc + {{(XLEN-IMMW){cur.instr[IMMW-1]}}, cur.instr[IMMW-1:0]};
         end
         UC_BR_ALU: begin
            kill_c   = 1'b1;
            target_c = cur.alu;
         end
         default: ;
      endcase
   end

   always_comb begin
      push_c = '0;
      case (cur.push)
         UC_PUSHALU:  push_c = {TYPE_INTEGER, cur.alu};
         UC_PUSHIMM:  push_c = cur.instr[SW-1:0];
         UC_PUSHREG0: push_c = cur.r0;
         UC_PUSHREG1: push_c = cur.r1;
         UC_PUSHBUS:  push_c = {TYPE_INTEGER, bus__rdata};
         default: ;
      endcase
      pop_c = (cur.pop == POPW'(POP_ALU)) ? cur.alu[POPW-1:0] : cur.pop;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state            <= S_IDLE;
         held             <= '0;
         cnt              <= '0;
         valid_4a         <= 1'b0;
         kill_4a          <= 1'b0;
         fault_4a         <= 1'b0;
         branch_target_4a <= '0;
         pc_4a            <= '0;
         c__to_push_4a    <= '0;
         st__to_push_4a   <= '0;
         st__to_pop_4a    <= '0;
         bus__req         <= 1'b0;
         bus__we          <= 1'b0;
         bus__addr        <= '0;
         bus__wdata       <= '0;
      end else begin
         valid_4a <= retire;
         kill_4a  <= retire && !tmo && kill_c;
         fault_4a <= tmo;
         if (retire) begin
            branch_target_4a <= target_c;
            pc_4a            <= cur.pc;
            c__to_push_4a    <= cur.push;
            st__to_push_4a   <= tmo ? '0 : push_c;
            st__to_pop_4a    <= pop_c;
         end
         if (accept_mem) begin
            held       <= live;
            cnt        <= '0;
            bus__req   <= 1'b1;
            bus__we    <= (live.mem == UC_MEM_STORE);
            bus__addr  <= live.alu[BUS_AW-1:0];
            bus__wdata <= live.r0[XLEN-1:0];
            state      <= S_WAIT;
         end else if (state == S_WAIT) begin
            if (bus__ack || tmo) begin
               bus__req <= 1'b0;
               bus__we  <= 1'b0;
               state    <= S_IDLE;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule
